// File: rtl/level_fifo_if.sv
// level_fifo_if: groups the write/read/flush requests and the data, flag and level
//   outputs of level_fifo into one bundle; the FIFO connects through the slave modport.
// Ports: i_clear/i_we/i_w_data/i_re driven by the user; o_* are driven by the FIFO.
interface level_fifo_if #(
    parameter int DBITS = 8,
    parameter int ABITS = 4
);
    logic             i_clear;
    logic             i_we;
    logic [DBITS-1:0] i_w_data;
    logic             i_re;
    logic [DBITS-1:0] o_r_data;
    logic             o_r_valid;
    logic             o_full;
    logic             o_empty;
    logic             o_almost_full;
    logic             o_almost_empty;
    logic [ABITS:0]   o_level;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_clear, i_we, i_w_data, i_re,
        input  o_r_data, o_r_valid, o_full, o_empty, o_almost_full, o_almost_empty,
               o_level, o_overflow, o_underflow
    );

    modport slave (
        input  i_clear, i_we, i_w_data, i_re,
        output o_r_data, o_r_valid, o_full, o_empty, o_almost_full, o_almost_empty,
               o_level, o_overflow, o_underflow
    );
endinterface

// File: rtl/level_fifo.sv
// level_fifo: synchronous FIFO, 2**ABITS entries, fill level, almost thresholds, sticky error flags, flush.
// Latency: write visible after 1 edge; read data combinational (SHOW_AHEAD=1) or registered +1 cycle (SHOW_AHEAD=0).
// Backpressure: none; a write while full without a read is dropped (overflow), a read while empty is rejected (underflow).
// Ports: i_clk clock, i_rst synchronous active-high reset, bus = level_fifo_if.slave
//   (i_clear flush, i_we/i_w_data write, i_re pop, o_r_data/o_r_valid read, flags, o_level).
module level_fifo #(
    parameter int DBITS      = 8,
    parameter int ABITS      = 4,
    parameter int AF_THRESH  = 2**ABITS - 2,
    parameter int AE_THRESH  = 2,
    parameter int SHOW_AHEAD = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    level_fifo_if.slave   bus
);
    localparam int DEPTH = 2**ABITS;
    localparam logic [ABITS:0] C_DEPTH = (ABITS+1)'(DEPTH);
    localparam logic [ABITS:0] C_AF    = (ABITS+1)'(AF_THRESH);
    localparam logic [ABITS:0] C_AE    = (ABITS+1)'(AE_THRESH);

    logic [DBITS-1:0] r_ram [DEPTH];
    logic [ABITS-1:0] r_wptr;
    logic [ABITS-1:0] r_rptr;
    logic [ABITS:0]   r_level;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_flush;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_full   = (r_level == C_DEPTH);
    assign w_empty  = (r_level == '0);
    assign w_flush  = i_rst | bus.i_clear;
    assign w_rd_acc = bus.i_re & ~w_empty;
    // A write into a full FIFO is still accepted when a pop frees the head slot in the same cycle.
    assign w_wr_acc = bus.i_we & (~w_full | w_rd_acc);

    always_ff @(posedge i_clk) begin
        if (w_flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + ABITS'(1);
            if (w_rd_acc) r_rptr <= r_rptr + ABITS'(1);
            if (w_wr_acc && !w_rd_acc)
                r_level <= r_level + (ABITS+1)'(1);
            else if (!w_wr_acc && w_rd_acc)
                r_level <= r_level - (ABITS+1)'(1);
            if (bus.i_we && !w_wr_acc) r_overflow  <= 1'b1;
            if (bus.i_re && !w_rd_acc) r_underflow <= 1'b1;
        end
    end

    // Storage is deliberately not reset; a write coinciding with reset/flush is discarded.
    always_ff @(posedge i_clk) begin
        if (!w_flush && w_wr_acc) r_ram[r_wptr] <= bus.i_w_data;
    end

    assign bus.o_full         = w_full;
    assign bus.o_empty        = w_empty;
    assign bus.o_almost_full  = (r_level >= C_AF);
    assign bus.o_almost_empty = (r_level <= C_AE);
    assign bus.o_level        = r_level;
    assign bus.o_overflow     = r_overflow;
    assign bus.o_underflow    = r_underflow;

    if (SHOW_AHEAD != 0) begin : g_show_ahead
        // Head entry is always presented; when empty it is whatever stale word sits at r_rptr.
        assign bus.o_r_data  = r_ram[r_rptr];
        assign bus.o_r_valid = ~w_empty;
    end else begin : g_registered
        logic [DBITS-1:0] r_r_data;
        logic             r_r_valid;

        always_ff @(posedge i_clk) begin
            if (w_flush) begin
                r_r_data  <= '0;
                r_r_valid <= 1'b0;
            end else begin
                r_r_valid <= w_rd_acc;
                if (w_rd_acc) r_r_data <= r_ram[r_rptr];
            end
        end

        assign bus.o_r_data  = r_r_data;
        assign bus.o_r_valid = r_r_valid;
    end
endmodule
